spi_ram: RTL
============

# spi_ram

Single-port command-driven memory that sits directly downstream of the SPI slave. It consumes each 10-bit frame the slave delivers on `rx_data`/`rx_valid`, decodes the 2-bit command prefix into write-address, write-data, read-address or read-data operations, and returns read bytes to the slave on `tx_data`/`tx_valid` for shifting out on MISO.

## Interface
- `MEM_DEPTH`, 256: number of 8-bit words; legal range 1..256.
- `ADDR_SIZE`, 8: address register width; fixed by the frame format, must be ≥ clog2(MEM_DEPTH).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  10  frame from the SPI slave; [9:8] = command, [7:0] = payload.
- `rx_valid`  in  1  `rx_data` is valid this cycle; one command executes per cycle it is high.
- `tx_data`  out  8  read-back byte to the SPI slave.
- `tx_valid`  out  1  `tx_data` holds a fresh read result.

## Operation
- Internal state: `wr_addr[7:0]`, `rd_addr[7:0]`, the memory array, `tx_data`, `tx_valid`.
- Commands are decoded only when `rx_valid`=1; with `rx_valid`=0 nothing changes except the `tx_valid` clear rule.
- 2'b00 WR_ADDR: `wr_addr` ← `rx_data[7:0]`.
- 2'b01 WR_DATA: mem[`wr_addr`] ← `rx_data[7:0]`.
- 2'b10 RD_ADDR: `rd_addr` ← `rx_data[7:0]`.
- 2'b11 RD_DATA: `tx_data` ← mem[`rd_addr`]; `tx_valid` ← 1. Payload bits are don't-care.
- `tx_valid` is held at 1 until the next accepted command whose code is not RD_DATA, or reset. A following RD_DATA reloads `tx_data` and keeps `tx_valid` at 1.
- `tx_data` holds its last value between reads; it changes only on RD_DATA or reset.
- Out-of-range address (≥ MEM_DEPTH): WR_DATA is dropped; RD_DATA returns 8'h00 and still asserts `tx_valid`.
- Reset (at any time, including between a RD_ADDR and its RD_DATA): `wr_addr`, `rd_addr`, `tx_data` ← 0; `tx_valid` ← 0. Memory contents are not reset and are preserved across reset.

## Timing
- All outputs registered. Reset values: `tx_data`=8'h00, `tx_valid`=0.
- WR_DATA: the write commits at the edge where `rx_valid` is sampled high. A RD_DATA to the same address on the very next cycle returns the new value.
- RD_DATA latency: one cycle. If sampled at edge N, `tx_data`/`tx_valid` are valid after edge N.
- WR_ADDR then WR_DATA on back-to-back cycles: the write uses the new address.
- RD_ADDR then RD_DATA on back-to-back cycles: the read uses the new address.
- `reset_n` low has priority over `rx_valid` in the same cycle. The command is discarded.

## Configuration
- `SPI_RAM_AUTO_INC_EN` defined:
  - After every executed WR_DATA, `wr_addr` ← `wr_addr`+1.
  - After every executed RD_DATA, `rd_addr` ← `rd_addr`+1.
  - Both wrap from MEM_DEPTH-1 to 0.
  - The increment still occurs when a write is dropped for an out-of-range address.
- Undefined: address registers change only on WR_ADDR/RD_ADDR. Repeated WR_DATA overwrites the same word; repeated RD_DATA rereads the same word.

## Structure
- Shared package `spi_pkg`:
  - Command codes `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - `FRAME_W`=10, `DATA_W`=8.
  - The SPI slave uses the same constants.
- One sub-module, `spi_ram_array`: MEM_DEPTH×8 storage with a synchronous write port (we, waddr, wdata) and a synchronous read port (re, raddr, rdata). It has no reset.
- `spi_ram` holds the decode, the address registers and the `tx_valid` logic.

## Test plan
- Reset with `rx_valid`=1 and frame 10'h0FF → `tx_data`=0, `tx_valid`=0; a following RD_DATA returns the pre-reset contents of address 0.
- Frames 10'b00_0000_0101, 10'b01_1010_0101, 10'b10_0000_0101, 10'b11_0000_0000 on consecutive cycles → `tx_data`=8'hA5 and `tx_valid`=1 one cycle after the last frame.
- After the previous case, a RD_ADDR frame → `tx_valid` drops to 0 after that edge and `tx_data` stays 8'hA5.
- Write 8'h3C to address 7, then 8'hC3 to address 7 → reading address 7 returns 8'hC3. With `SPI_RAM_AUTO_INC_EN` defined, the second write lands at address 8, and reads from address 7 return 8'h3C then 8'hC3.
- Build with MEM_DEPTH=16: WR_DATA 8'hFF at address 20 → memory unchanged; RD_DATA at address 20 → `tx_data`=8'h00 and `tx_valid`=1.
- With `SPI_RAM_AUTO_INC_EN` defined: WR_ADDR 255, then WR_DATA 8'h11, then WR_DATA 8'h22 → mem[255]=8'h11 and mem[0]=8'h22 (wrap).

Source files
------------

// File: rtl/spi_pkg.sv
// Constants shared by spi_ram and the SPI slave: frame layout and command codes.
package spi_pkg;

   localparam int unsigned FRAME_W = 10;
   localparam int unsigned DATA_W  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_ram_array.sv
// DEPTH x 8 storage, synchronous write and synchronous read ports, no reset.
module spi_ram_array
   import spi_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  widx;
   logic [IDX_W-1:0]  ridx;

   // Callers gate we/re with the range check, so only the low index bits matter.
   assign widx = waddr[IDX_W-1:0];
   assign ridx = raddr[IDX_W-1:0];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
      if (re) begin
         rdata <= mem[ridx];
      end
   end

endmodule

// File: rtl/spi_ram.sv
// Command decoder and address registers in front of spi_ram_array.
// Optional address auto-increment is enabled by defining SPI_RAM_AUTO_INC_EN.
module spi_ram
   import spi_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_SIZE = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [FRAME_W-1:0] rx_data,
   input  logic               rx_valid,
   output logic [DATA_W-1:0]  tx_data,
   output logic               tx_valid
);

   localparam logic [ADDR_SIZE:0] DEPTH_LIM = (ADDR_SIZE + 1)'(MEM_DEPTH);
`ifdef SPI_RAM_AUTO_INC_EN
   localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);
`endif

   logic [1:0]           cmd;
   logic [ADDR_SIZE-1:0] pay_addr;
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 rd_zero_q, rd_zero_d;
   logic                 wr_in_range, rd_in_range;
   logic                 mem_we, mem_re;
   logic [DATA_W-1:0]    mem_rdata;

   assign cmd         = rx_data[FRAME_W-1:DATA_W];
   assign pay_addr    = ADDR_SIZE'(rx_data[DATA_W-1:0]);
   assign wr_in_range = {1'b0, wr_addr_q} < DEPTH_LIM;
   assign rd_in_range = {1'b0, rd_addr_q} < DEPTH_LIM;

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      tx_valid_d = tx_valid_q;
      rd_zero_d  = rd_zero_q;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      if (rx_valid) begin
         tx_valid_d = 1'b0;
         case (cmd)
            CMD_WR_ADDR: wr_addr_d = pay_addr;
            CMD_WR_DATA: begin
               mem_we = wr_in_range;
`ifdef SPI_RAM_AUTO_INC_EN
               wr_addr_d = (wr_addr_q == ADDR_LAST) ? '0 : wr_addr_q + ADDR_SIZE'(1);
`endif
            end
            CMD_RD_ADDR: rd_addr_d = pay_addr;
            default: begin
               // Out-of-range reads leave the array port idle and force the output to zero.
               mem_re     = rd_in_range;
               rd_zero_d  = ~rd_in_range;
               tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
               rd_addr_d = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_SIZE'(1);
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         tx_valid_q <= 1'b0;
         rd_zero_q  <= 1'b1;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         tx_valid_q <= tx_valid_d;
         rd_zero_q  <= rd_zero_d;
      end
   end

   // Array has no reset, so a command arriving during reset must not touch it.
   spi_ram_array #(
      .DEPTH  (MEM_DEPTH),
      .ADDR_W (ADDR_SIZE)
   ) u_array (
      .clk   (clk),
      .we    (mem_we & reset_n),
      .waddr (wr_addr_q),
      .wdata (rx_data[DATA_W-1:0]),
      .re    (mem_re & reset_n),
      .raddr (rd_addr_q),
      .rdata (mem_rdata)
   );

   assign tx_data  = rd_zero_q ? '0 : mem_rdata;
   assign tx_valid = tx_valid_q;

endmodule
